div_word_loader: RTL
====================

# div_word_loader

Serial front/back end for the 512-bit non-restoring divider. It accepts dividend and divisor as a stream of 32-bit words, drives the divider's wide operand inputs, and pulses `start`. It waits for `done`, then streams quotient and remainder back out as 32-bit words. It sits between the RSA decryption datapath's word bus and the `nonrestoringdiv` instance, and it is the only block that drives that instance.

## Interface
- `WIDTH`, 512, operand width; must equal the divider width and be a multiple of `WORD`.
- `WORD`, 32, stream word width; `NW = WIDTH/WORD` (16 at defaults).
- `clk`  in  1  rising-edge clock shared with the divider.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block accepts an input word.
- `in_data`  in  WORD  input word; dividend words first, then divisor words, each least-significant word first.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts an output word.
- `out_data`  out  WORD  output word; quotient words, then remainder words, each least-significant word first.
- `out_last`  out  1  high with the final (2·NW-th) output word.
- `div_err`  out  1  sticky divide-by-zero flag for the current result (see Configuration).
- `busy`  out  1  high in every state except S_LOAD.
- `div_start`  out  1  to divider `start`.
- `div_q`  out  WIDTH  to divider `Q` (dividend).
- `div_m`  out  WIDTH  to divider `M` (divisor).
- `div_a`  out  WIDTH  to divider `A`; constant 0.
- `div_done`  in  1  from divider `done`.
- `div_qout`  in  WIDTH  from divider `Q_out`.
- `div_r`  in  WIDTH  from divider `R`.

## Operation
- FSM states: S_LOAD, S_START, S_WAIT, S_OUT.
- One word counter `cnt`, range 0..2·NW−1, is used in S_LOAD and S_OUT.
- S_LOAD:
  - `in_ready`=1.
  - On `in_valid&&in_ready`, word `cnt` goes to `div_q[cnt*WORD +: WORD]` for `cnt`<NW, and to `div_m[(cnt−NW)*WORD +: WORD]` otherwise; then `cnt`++.
  - When the word with `cnt`=2·NW−1 is accepted: `cnt`←0, go to S_START.
- S_START:
  - `div_start`=1 for exactly this one cycle.
  - Then go to S_WAIT.
  - `div_q`/`div_m` hold stable from S_START until the next S_LOAD write.
- S_WAIT:
  - `div_done` is ignored in the first S_WAIT cycle, which masks a stale `done` from the previous operation.
  - From the second cycle on, the first cycle with `div_done`=1 captures `div_qout` into the quotient register and `div_r` into the remainder register, then goes to S_OUT.
  - No timeout.
- S_OUT:
  - `out_valid`=1.
  - `out_data` = quotient word `cnt` for `cnt`<NW, else remainder word `cnt`−NW.
  - `out_last`=(`cnt`==2·NW−1).
  - On `out_valid&&out_ready`: `cnt`++.
  - After the last word: `cnt`←0, `div_err`←0, go to S_LOAD.
- Output data and `out_last` hold stable while `out_valid&&!out_ready`.
- In S_LOAD, `in_data` is accepted only under `in_ready`; `in_valid` outside S_LOAD has no effect.
- Reset:
  - State←S_LOAD, `cnt`←0, quotient/remainder/`div_q`/`div_m`←0.
  - `in_ready`, `out_valid`, `out_last`, `div_err`, `div_start`, `busy`, `out_data` all 0 during the reset cycle.
  - `in_ready`=1 from the first cycle after reset deasserts.
- Reset in any state, including mid-S_WAIT or mid-S_OUT, aborts the operation and discards partial results. A later `div_done` from the aborted divide is not captured, because the state is S_LOAD.

## Timing
- Input: 2·NW accepted words, one per cycle at most; 32 cycles minimum at defaults.
- Last input word accepted at edge T: S_START during T+1 (`div_start`=1), S_WAIT from T+2.
- `div_done` sampled high at edge D (D ≥ T+3): `out_valid`=1 from cycle D+1, with `out_data` = quotient word 0.
- Output: 2·NW words, one per cycle when `out_ready`=1.
- `in_ready`=1 in the cycle after the last output handshake.
- `in_ready` and `out_valid` are never high in the same cycle.
- All outputs are registered except `out_data`/`out_last`, which are muxed from registers by `cnt`.

## Configuration
- Macro `DIV_LOADER_ZERO_CHECK_EN`.
- Defined:
  - On the transition S_LOAD→S_START, if the full divisor is 0, go to S_OUT directly instead of S_START; `div_start` is never pulsed.
  - Quotient register ← all ones; remainder register ← dividend; `div_err`←1.
  - `div_err` stays 1 until the last output handshake or reset.
- Not defined:
  - No check; a zero divisor is passed to the divider unchanged.
  - `div_err` is tied to 0.

## Test plan
- Dividend 100, divisor 7 (upper words 0), `out_ready`=1 → one `div_start` pulse; output word 0 = 14, word 16 = 2, all other words 0; `out_last` only on word 31.
- Dividend 2^512−1, divisor 1 → quotient words all 0xFFFFFFFF, remainder words all 0.
- Divisor 0 with `DIV_LOADER_ZERO_CHECK_EN`:
  - Dividend 5 → no `div_start`; quotient all ones; remainder word 0 = 5; `div_err`=1 through the last word, then 0.
  - Without the macro, `div_start` pulses once.
- Backpressure: `in_valid` toggled randomly and `out_ready` at 1/3 duty, with dividend 1000, divisor 3 → words captured in order; quotient 333, remainder 1; `out_data` stable during stalls.
- Stale done: `div_done` held high across S_START and S_WAIT's first cycle → capture occurs no earlier than S_WAIT's second cycle.
- `rst` asserted in S_WAIT, then `div_done` pulsed → no output, `in_ready`=1 the cycle after reset releases; a fresh 100/7 operation then completes correctly.

Source files
------------

// File: rtl/div_word_loader.sv
// div_word_loader
// ---------------------------------------------------------------------------
// Serial front/back end for the wide non-restoring divider. A stream of WORD-bit
// words (dividend first, then divisor, each least-significant word first) is
// gathered into the divider operand registers. The block pulses div_start and
// waits for div_done. It then streams the quotient and then the remainder back
// out, again least-significant word first.
//
// Optional feature macro: DIV_LOADER_ZERO_CHECK_EN
//   defined   : an all-zero divisor bypasses the divider. The quotient becomes
//               all ones, the remainder becomes the dividend, and div_err is
//               set until the last output handshake.
//   undefined : no check is made, and div_err is tied low.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input word handshake, in_data = WORD-bit word
//   out_valid/out_ready   output word handshake, out_data = WORD-bit word
//   out_last              marks the final (2*NW-th) output word
//   div_err               sticky divide-by-zero flag for the current result
//   busy                  high whenever the block is not loading operands
//   div_start             one-cycle start pulse to the divider
//   div_q, div_m, div_a   divider operands (dividend, divisor, constant 0)
//   div_done              divider completion
//   div_qout, div_r       divider quotient and remainder
// ---------------------------------------------------------------------------
module div_word_loader #(
  parameter int WIDTH = 512,
  parameter int WORD  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD-1:0]  out_data,
  output logic             out_last,
  output logic             div_err,
  output logic             busy,
  output logic             div_start,
  output logic [WIDTH-1:0] div_q,
  output logic [WIDTH-1:0] div_m,
  output logic [WIDTH-1:0] div_a,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_qout,
  input  logic [WIDTH-1:0] div_r
);

  localparam int NW    = WIDTH / WORD;
  localparam int CNT_W = $clog2(2 * NW);
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_NW   = CNT_W'(NW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * NW - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                    state_r, state_nxt_s;
  logic [CNT_W-1:0]          cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]          idx_s;
  logic                      in_fire_s, out_fire_s, capture_s;
  logic                      wait_armed_r;
  logic                      in_ready_r, out_valid_r, busy_r, div_start_r;
  logic [NW-1:0][WORD-1:0]   dq_r, dm_r, quot_r, rem_r;
  logic [WORD-1:0]           out_word_s;
`ifdef DIV_LOADER_ZERO_CHECK_EN
  logic                      zero_s;
  logic                      div_err_r;
  logic [NW-1:0][WORD-1:0]   dm_full_s;
`endif

  // Word index within the operand/result half selected by cnt.
  always_comb begin
    idx_s = {IDX_W{1'b0}};
    if (cnt_r < CNT_NW) begin
      idx_s = IDX_W'(cnt_r);
    end else begin
      idx_s = IDX_W'(cnt_r - CNT_NW);
    end
  end

`ifdef DIV_LOADER_ZERO_CHECK_EN
  // The complete divisor as it will look once the in-flight top word lands.
  always_comb begin
    dm_full_s         = dm_r;
    dm_full_s[NW - 1] = in_data;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_LOAD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, counter and datapath-strobe decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    in_fire_s   = 1'b0;
    out_fire_s  = 1'b0;
    capture_s   = 1'b0;
`ifdef DIV_LOADER_ZERO_CHECK_EN
    zero_s      = 1'b0;
`endif
    case (state_r)
      S_LOAD: begin
        if (in_valid && in_ready_r) begin
          in_fire_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            cnt_nxt_s = CNT_ZERO;
`ifdef DIV_LOADER_ZERO_CHECK_EN
            if (dm_full_s == {WIDTH{1'b0}}) begin
              zero_s      = 1'b1;
              state_nxt_s = S_OUT;
            end else begin
              state_nxt_s = S_START;
            end
`else
            state_nxt_s = S_START;
`endif
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          state_nxt_s = S_LOAD;
        end
      end
      S_START: begin
        state_nxt_s = S_WAIT;
      end
      S_WAIT: begin
        // A done seen in the first wait cycle may be left over from the
        // previous divide, so only an armed wait may capture.
        if (wait_armed_r && div_done) begin
          capture_s   = 1'b1;
          state_nxt_s = S_OUT;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_OUT: begin
        if (out_valid_r && out_ready) begin
          out_fire_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = S_LOAD;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          state_nxt_s = S_OUT;
        end
      end
      default: begin
        state_nxt_s = S_LOAD;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Word counter and wait-arm flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= CNT_ZERO;
      wait_armed_r <= 1'b0;
    end else begin
      cnt_r        <= cnt_nxt_s;
      wait_armed_r <= (state_r == S_WAIT);
    end
  end

  // Registered handshake and status outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      div_start_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == S_LOAD);
      out_valid_r <= (state_nxt_s == S_OUT);
      busy_r      <= (state_nxt_s != S_LOAD);
      div_start_r <= (state_nxt_s == S_START);
    end
  end

  // Operand capture from the input stream and result capture from the divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      dq_r   <= {WIDTH{1'b0}};
      dm_r   <= {WIDTH{1'b0}};
      quot_r <= {WIDTH{1'b0}};
      rem_r  <= {WIDTH{1'b0}};
    end else begin
      if (in_fire_s) begin
        if (cnt_r < CNT_NW) begin
          dq_r[idx_s] <= in_data;
        end else begin
          dm_r[idx_s] <= in_data;
        end
      end
      if (capture_s) begin
        quot_r <= div_qout;
        rem_r  <= div_r;
      end
`ifdef DIV_LOADER_ZERO_CHECK_EN
      if (zero_s) begin
        quot_r <= {WIDTH{1'b1}};
        rem_r  <= dq_r;
      end
`endif
    end
  end

`ifdef DIV_LOADER_ZERO_CHECK_EN
  // Divide-by-zero flag, held for the whole result stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_err_r <= 1'b0;
    end else if (zero_s) begin
      div_err_r <= 1'b1;
    end else if (out_fire_s && (cnt_r == CNT_LAST)) begin
      div_err_r <= 1'b0;
    end else begin
      div_err_r <= div_err_r;
    end
  end

  assign div_err = div_err_r;
`else
  assign div_err = 1'b0;
`endif

  // Output word mux: quotient words first, then remainder words.
  always_comb begin
    out_word_s = {WORD{1'b0}};
    if (cnt_r < CNT_NW) begin
      out_word_s = quot_r[idx_s];
    end else begin
      out_word_s = rem_r[idx_s];
    end
  end

  assign out_data  = out_valid_r ? out_word_s : {WORD{1'b0}};
  assign out_last  = out_valid_r && (cnt_r == CNT_LAST);
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign div_start = div_start_r;
  assign div_q     = dq_r;
  assign div_m     = dm_r;
  assign div_a     = {WIDTH{1'b0}};

endmodule
